// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Avalon-MM slave that time-multiplexes one shared 7-segment bus across
// NUM_DIGITS common-anode digits. Each digit slot is SCAN_DIV cycles long. It
// starts with BLANK_CYCLES all-off cycles, which stop ghosting between digits.
// Digit data and display controls are latched into shadow registers at each
// frame start, so a frame never shows a mix of old and new values.
//
// Ports
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   address      in   [1:0]  register select (0 DIGITS, 1 CTRL, 2 STATUS, 3 -)
//   chipselect   in   slave select
//   write_n      in   active-low write strobe
//   writedata    in   [31:0] write data
//   readdata     out  [31:0] combinational readback of the live registers
//   seg_n        out  [6:0]  segments g..a, active-low
//   dp_n         out  decimal point, active-low
//   digit_en     out  [NUM_DIGITS-1:0] one-hot digit enables, active-high
//   frame_tick   out  one-cycle pulse on the first BLANK cycle of each frame
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_tick
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0]     SHOW_LAST  = SLOT_W'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0]    FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  // Live (software-visible) registers
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic                    r_enable;
  logic                    r_hex_mode;
  logic [NUM_DIGITS-1:0]   r_blink_mask;
  logic [NUM_DIGITS-1:0]   r_dp_mask;

  // Shadow copies that actually drive the display
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic                    r_sh_hex_mode;
  logic [NUM_DIGITS-1:0]   r_sh_blink_mask;
  logic [NUM_DIGITS-1:0]   r_sh_dp_mask;

  // Scan state
  state_t                  r_state;
  logic [SLOT_W-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [FRAME_W-1:0]      r_frame_cnt;
  logic                    r_blink_phase;

  // Registered outputs
  logic [6:0]              r_seg_n;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_tick;

  // Next-state / next-output values
  state_t                  w_state_next;
  logic [SLOT_W-1:0]       w_slot_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic [FRAME_W-1:0]      w_frame_next;
  logic                    w_blink_next;
  logic                    w_tick_next;
  logic                    w_load_shadow;
  logic [6:0]              w_seg_n_next;
  logic                    w_dp_n_next;
  logic [NUM_DIGITS-1:0]   w_digit_en_next;

  logic                    w_wr_digits;
  logic                    w_wr_ctrl;
  logic                    w_unused_wdata;
  logic [3:0]              w_sh_nibble [NUM_DIGITS];

  // Only some writedata bits are stored; fold the rest away.
  assign w_unused_wdata = ^writedata;

  assign w_wr_digits = chipselect && !write_n && (address == 2'd0);
  assign w_wr_ctrl   = chipselect && !write_n && (address == 2'd1);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
    assign w_sh_nibble[gi] = r_sh_digits[4*gi +: 4];
  end

  function automatic logic [6:0] f_decode(input logic [3:0] i_nib, input logic i_hex);
    logic [6:0] v_pat;
    case (i_nib)
      4'h0: v_pat = 7'h3F;
      4'h1: v_pat = 7'h06;
      4'h2: v_pat = 7'h5B;
      4'h3: v_pat = 7'h4F;
      4'h4: v_pat = 7'h66;
      4'h5: v_pat = 7'h6D;
      4'h6: v_pat = 7'h7D;
      4'h7: v_pat = 7'h07;
      4'h8: v_pat = 7'h7F;
      4'h9: v_pat = 7'h6F;
      4'hA: v_pat = 7'h77;
      4'hB: v_pat = 7'h7C;
      4'hC: v_pat = 7'h39;
      4'hD: v_pat = 7'h5E;
      4'hE: v_pat = 7'h79;
      default: v_pat = 7'h71;
    endcase
    // In BCD mode the letters are not digits, so show nothing.
    if (i_nib > 4'd9 && !i_hex) begin
      v_pat = 7'h00;
    end
    return v_pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin : p_regs
    if (!reset_n) begin
      r_digits     <= '0;
      r_enable     <= 1'b0;
      r_hex_mode   <= 1'b0;
      r_blink_mask <= '0;
      r_dp_mask    <= '0;
    end else begin
      if (w_wr_digits) begin
        r_digits <= writedata[4*NUM_DIGITS-1:0];
      end
      if (w_wr_ctrl) begin
        r_enable     <= writedata[0];
        r_hex_mode   <= writedata[1];
        r_blink_mask <= writedata[8 +: NUM_DIGITS];
        r_dp_mask    <= writedata[16 +: NUM_DIGITS];
      end
    end
  end

  always_comb begin : p_readdata
    readdata = '0;
    case (address)
      2'd0: readdata[4*NUM_DIGITS-1:0] = r_digits;
      2'd1: begin
        readdata[0]               = r_enable;
        readdata[1]               = r_hex_mode;
        readdata[8 +: NUM_DIGITS]  = r_blink_mask;
        readdata[16 +: NUM_DIGITS] = r_dp_mask;
      end
      2'd2: begin
        readdata[IDX_W-1:0] = r_idx;
        readdata[8]         = r_blink_phase;
        readdata[9]         = (r_state == S_SHOW);
      end
      default: readdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin : p_state
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin : p_next
    w_state_next    = r_state;
    w_slot_next     = r_slot_cnt;
    w_idx_next      = r_idx;
    w_frame_next    = r_frame_cnt;
    w_blink_next    = r_blink_phase;
    w_tick_next     = 1'b0;
    w_load_shadow   = 1'b0;
    w_seg_n_next    = 7'h7F;
    w_dp_n_next     = 1'b1;
    w_digit_en_next = '0;

    if (!r_enable) begin
      // Disabling wins over everything: drop straight to a clean idle.
      w_state_next = S_IDLE;
      w_slot_next  = '0;
      w_idx_next   = '0;
      w_frame_next = '0;
      w_blink_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_BLANK;
          w_slot_next  = '0;
          w_idx_next   = '0;
          w_frame_next = '0;
          w_blink_next = 1'b0;
        end
        S_BLANK: begin
          if (r_slot_cnt == BLANK_LAST) begin
            w_state_next = S_SHOW;
            w_slot_next  = '0;
          end else begin
            w_slot_next = r_slot_cnt + SLOT_W'(1);
          end
        end
        S_SHOW: begin
          if (r_slot_cnt == SHOW_LAST) begin
            w_state_next = S_BLANK;
            w_slot_next  = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_next  = '0;
              w_tick_next = 1'b1;
              if (r_frame_cnt == FRAME_LAST) begin
                w_frame_next = '0;
                w_blink_next = !r_blink_phase;
              end else begin
                w_frame_next = r_frame_cnt + FRAME_W'(1);
              end
            end else begin
              w_idx_next = r_idx + IDX_W'(1);
            end
          end else begin
            w_slot_next = r_slot_cnt + SLOT_W'(1);
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_slot_next  = '0;
          w_idx_next   = '0;
          w_frame_next = '0;
          w_blink_next = 1'b0;
        end
      endcase
    end

    // Shadow capture on the edge that enters the first BLANK of a frame. A
    // write landing on the same edge only reaches the live register.
    w_load_shadow = (w_state_next == S_BLANK) && (r_state != S_BLANK) &&
                    (w_idx_next == '0);

    // Outputs are computed for the state being entered so they are
    // registered and change on the entering edge.
    if (w_state_next == S_SHOW) begin
      w_digit_en_next = DIGIT0 << w_idx_next;
      if (!(r_sh_blink_mask[w_idx_next] && w_blink_next)) begin
        w_seg_n_next = ~f_decode(w_sh_nibble[w_idx_next], r_sh_hex_mode);
        w_dp_n_next  = ~r_sh_dp_mask[w_idx_next];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_scan
    if (!reset_n) begin
      r_slot_cnt      <= '0;
      r_idx           <= '0;
      r_frame_cnt     <= '0;
      r_blink_phase   <= 1'b0;
      r_sh_digits     <= '0;
      r_sh_hex_mode   <= 1'b0;
      r_sh_blink_mask <= '0;
      r_sh_dp_mask    <= '0;
      r_seg_n         <= 7'h7F;
      r_dp_n          <= 1'b1;
      r_digit_en      <= '0;
      r_frame_tick    <= 1'b0;
    end else begin
      r_slot_cnt    <= w_slot_next;
      r_idx         <= w_idx_next;
      r_frame_cnt   <= w_frame_next;
      r_blink_phase <= w_blink_next;
      r_seg_n       <= w_seg_n_next;
      r_dp_n        <= w_dp_n_next;
      r_digit_en    <= w_digit_en_next;
      r_frame_tick  <= w_tick_next;
      if (w_load_shadow) begin
        r_sh_digits     <= r_digits;
        r_sh_hex_mode   <= r_hex_mode;
        r_sh_blink_mask <= r_blink_mask;
        r_sh_dp_mask    <= r_dp_mask;
      end
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign digit_en   = r_digit_en;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Bench for seven_seg_scan_ctrl with a small scan geometry. A behavioural
// model derives the expected display from the number of cycles since the scan
// started (slot = t/SCAN_DIV, frame = t/frame_len) and is compared every cycle
// with all outputs. A register-access table and hand-written sequences cover
// the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 16;
  localparam int BC    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [ND-1:0] digit_en;
  logic        frame_tick;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .digit_en  (digit_en),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        m_en = 1'b0, m_hex = 1'b0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_blink = '0, m_dp = '0;
  logic        m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] s_dig = '0;
  logic        s_hex = 1'b0;
  logic [3:0]  s_blink = '0, s_dp = '0;
  logic        mon_on = 1'b0;

  always @(posedge clk or negedge reset_n) begin : p_model
    int t_new;
    if (!reset_n) begin
      m_en <= 0; m_hex <= 0; m_dig <= '0; m_blink <= '0; m_dp <= '0;
      m_run <= 0; m_t <= 0;
      s_dig <= '0; s_hex <= 0; s_blink <= '0; s_dp <= '0;
    end else begin
      t_new = (m_en && m_run) ? m_t + 1 : 0;
      m_run <= m_en;
      m_t   <= t_new;
      if (m_en && (t_new % FRAME == 0)) begin
        s_dig <= m_dig; s_hex <= m_hex; s_blink <= m_blink; s_dp <= m_dp;
      end
      if (chipselect && !write_n) begin
        if (address == 2'd0) m_dig <= writedata[15:0];
        if (address == 2'd1) begin
          m_en <= writedata[0]; m_hex <= writedata[1];
          m_blink <= writedata[11:8]; m_dp <= writedata[19:16];
        end
      end
    end
  end

  // {digit_en, seg_n, dp_n, frame_tick, readdata}
  function automatic logic [44:0] model_out(input logic [1:0] addr);
    int idx;
    logic show, bp, tick, dp;
    logic [3:0] en, nib;
    logic [6:0] seg, pat;
    logic [31:0] rd;
    idx = 0; show = 0; bp = 0; tick = 0; en = '0; seg = 7'h7F; dp = 1'b1;
    if (m_run) begin
      idx  = (m_t / SD) % ND;
      show = (m_t % SD) >= BC;
      bp   = (((m_t / FRAME) / BF) % 2) != 0;
      tick = (m_t % FRAME == 0) && (m_t != 0);
      if (show) begin
        en  = 4'b0001 << idx;
        nib = s_dig[idx*4 +: 4];
        pat = (nib > 4'd9 && !s_hex) ? 7'h00 : seg_tab[nib];
        if (!(s_blink[idx] && bp)) begin
          seg = ~pat;
          dp  = ~s_dp[idx];
        end
      end
    end
    case (addr)
      2'd0: rd = {16'h0, m_dig};
      2'd1: rd = {12'h0, m_dp, 4'h0, m_blink, 6'h0, m_hex, m_en};
      2'd2: rd = {22'h0, show, bp, 5'h0, 3'(idx)};
      default: rd = 32'h0;
    endcase
    return {en, seg, dp, tick, rd};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      check("cycle", {19'h0, digit_en, seg_n, dp_n, frame_tick, readdata}, {19'h0, model_out(address)});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      address = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame_tick && cycles < 300);
    if (!frame_tick) timeout_fail("wait_frame_tick");
  endtask

  task automatic wait_en(input logic [ND-1:0] pat);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (digit_en !== pat && c < 300);
    if (digit_en !== pat) timeout_fail("wait_digit_en");
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
  } reg_vec_t;

  reg_vec_t tbl [8];

  initial begin
    int c, blanked;
    logic prev;

    tbl[0] = '{2'd0, 1'b1, 1'b0, 32'h0000_1234, 2'd0, 32'h0000_1234};
    tbl[1] = '{2'd0, 1'b0, 1'b0, 32'h0000_FFFF, 2'd0, 32'h0000_1234};
    tbl[2] = '{2'd0, 1'b1, 1'b1, 32'h0000_FFFF, 2'd0, 32'h0000_1234};
    tbl[3] = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 2'd1, 32'h000F_0F02};
    tbl[4] = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
    tbl[5] = '{2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    tbl[6] = '{2'd0, 1'b1, 1'b0, 32'hABCD_5678, 2'd0, 32'h0000_5678};
    tbl[7] = '{2'd1, 1'b1, 1'b0, 32'h0000_0000, 2'd1, 32'h0000_0000};

    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // 1: idle after reset
    idle_cycles(100);

    // Register access table (scan stays disabled throughout)
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      address = tbl[i].addr; writedata = tbl[i].wdata;
      chipselect = tbl[i].cs; write_n = tbl[i].wn;
      @(posedge clk); #2;
      chipselect = 1'b0; write_n = 1'b1; address = tbl[i].raddr;
      @(negedge clk);
      check($sformatf("reg_vec%0d", i), {32'h0, readdata}, {32'h0, tbl[i].exp_rd});
    end

    // 2: basic scan of 0x1234
    bus_write(2'd0, 32'h1234);
    bus_write(2'd1, 32'h1);
    wait_tick(c);
    wait_tick(c);
    check("frame_period", 64'(c), 64'(FRAME));
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("digit_en_t%0d", k), {60'h0, digit_en},
            {60'h0, ((k % SD) >= BC) ? (4'b0001 << (k / SD)) : 4'b0000});
      if (k == 4)  check("seg_d0_4", {57'h0, seg_n}, {57'h0, 7'h19});
      if (k == 20) check("seg_d1_3", {57'h0, seg_n}, {57'h0, 7'h30});
      if (k == 36) check("seg_d2_2", {57'h0, seg_n}, {57'h0, 7'h24});
      if (k == 52) check("seg_d3_1", {57'h0, seg_n}, {57'h0, 7'h79});
    end

    // 3: letters blank in BCD mode, shown in hex mode
    bus_write(2'd0, 32'h00AB);
    wait_tick(c);
    repeat (4) @(negedge clk);
    check("bcd_B_blank", {53'h0, digit_en, seg_n}, {53'h0, 4'b0001, 7'h7F});
    repeat (16) @(negedge clk);
    check("bcd_A_blank", {53'h0, digit_en, seg_n}, {53'h0, 4'b0010, 7'h7F});
    bus_write(2'd1, 32'h3);
    wait_tick(c);
    repeat (4) @(negedge clk);
    check("hex_b", {53'h0, digit_en, seg_n}, {53'h0, 4'b0001, 7'h03});
    repeat (16) @(negedge clk);
    check("hex_A", {53'h0, digit_en, seg_n}, {53'h0, 4'b0010, 7'h08});

    // 4: blink digits 0 and 1
    bus_write(2'd0, 32'h1234);
    bus_write(2'd1, 32'h0301);
    @(posedge clk); #2 address = 2'd2;
    @(negedge clk);
    prev = readdata[8];
    c = 0;
    while (readdata[8] == prev && c < 300) begin @(negedge clk); c++; end
    if (readdata[8] == prev) timeout_fail("blink_toggle1");
    prev = readdata[8];
    c = 0;
    blanked = 0;
    while (readdata[8] == prev && c < 300) begin
      if (digit_en != 0 && seg_n == 7'h7F) blanked++;
      @(negedge clk); c++;
    end
    check("blink_half_period", 64'(c), 64'(2 * FRAME));
    prev = readdata[8];
    c = 0;
    while (readdata[8] == prev && c < 300) begin
      if (digit_en != 0 && seg_n == 7'h7F) blanked++;
      @(negedge clk); c++;
    end
    check("blank_cycles_per_period", 64'(blanked), 64'(2 * 2 * (SD - BC)));

    // 5: write during SHOW of digit 2 takes effect next frame
    bus_write(2'd1, 32'h1);
    wait_tick(c);
    wait_tick(c);
    wait_en(4'b0100);
    bus_write(2'd0, 32'h5678);
    @(negedge clk);
    check("readback_live", {32'h0, readdata}, {32'h0, 32'h5678});
    wait_en(4'b1000);
    check("old_frame_d3", {57'h0, seg_n}, {57'h0, 7'h79});
    wait_tick(c);
    repeat (4) @(negedge clk);
    check("new_frame_d0", {53'h0, digit_en, seg_n}, {53'h0, 4'b0001, 7'h00});

    // write landing on the shadow-load edge waits one more frame
    wait_tick(c);
    repeat (62) @(negedge clk);
    bus_write(2'd0, 32'h9999);
    @(negedge clk);
    check("wrap_tick", {63'h0, frame_tick}, {63'h0, 1'b1});
    repeat (4) @(negedge clk);
    check("same_edge_old", {57'h0, seg_n}, {57'h0, 7'h00});
    wait_tick(c);
    repeat (4) @(negedge clk);
    check("same_edge_new", {57'h0, seg_n}, {57'h0, 7'h10});

    // 6: disable mid-SHOW, then re-enable
    wait_en(4'b0010);
    bus_write(2'd1, 32'h0);
    address = 2'd2;
    @(negedge clk);
    @(negedge clk);
    check("disable_off", {19'h0, digit_en, seg_n, dp_n, frame_tick, readdata},
          {19'h0, 4'b0000, 7'h7F, 1'b1, 1'b0, 32'h0});
    bus_write(2'd1, 32'h1);
    address = 2'd2;
    @(negedge clk);
    check("reenable_idle", {32'h0, 28'h0, digit_en}, {32'h0, 28'h0, 4'b0000});
    repeat (5) @(negedge clk);
    check("reenable_first_show", {28'h0, digit_en, readdata}, {28'h0, 4'b0001, 32'h200});

    // asynchronous reset mid-scan
    wait_en(4'b0100);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("async_reset", {19'h0, digit_en, seg_n, dp_n, frame_tick, readdata},
          {19'h0, 4'b0000, 7'h7F, 1'b1, 1'b0, 32'h0});
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1; address = 2'd1;
    @(negedge clk);
    check("ctrl_after_reset", {32'h0, readdata}, {32'h0, 32'h0});

    // Randomized traffic against the model
    for (int i = 0; i < 24; i++) begin
      int op;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      d  = $urandom;
      if (op <= 3) begin
        bus_write(2'd0, d);
      end else if (op <= 7) begin
        d[0] = ($urandom_range(0, 5) != 0);
        bus_write(2'd1, d);
      end else if (op == 8) begin
        bus_write(2'($urandom_range(2, 3)), d);
      end
      idle_cycles($urandom_range(0, 150));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
